// File: rtl/alu_seq.sv
// Sequencer that issues a wide operation to an 8-bit clocked ALU slice, LSB slice first,
// and reassembles the result. Optional rsp_zero output enabled by ALU_SEQ_ZERO_FLAG_EN.
module alu_seq #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned LANES       = 4,
  parameter int unsigned ALU_LATENCY = 1,
  parameter logic [15:0] CHAIN_MASK  = 16'h0003
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_opcode,
  input  logic [WIDTH*LANES-1:0] cmd_a,
  input  logic [WIDTH*LANES-1:0] cmd_b,
  input  logic                   cmd_carry_in,
  output logic [WIDTH-1:0]       alu_in_a,
  output logic [WIDTH-1:0]       alu_in_b,
  output logic [3:0]             alu_opcode,
  output logic                   alu_carry_in,
  input  logic [WIDTH-1:0]       alu_sum,
  input  logic                   alu_carry_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH*LANES-1:0] rsp_result,
  output logic                   rsp_carry
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic                   rsp_zero
`endif
);

  localparam int unsigned FW = WIDTH * LANES;
  localparam int unsigned KW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d, k_nxt;
  logic [2:0]      wcnt_q, wcnt_d;
  logic [FW-1:0]   a_q, a_d, b_q, b_d;
  logic [3:0]      op_q, op_d;
  logic            cin_q, cin_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic            alu_cin_q, alu_cin_d;
  logic [FW-1:0]   res_q, res_d;
  logic            carry_q, carry_d;
  logic            last_wait, last_lane;

  assign cmd_ready = rst_n && (state_q == S_IDLE);
  assign k_nxt     = k_q + KW'(1);
  assign last_wait = (wcnt_q == 3'(ALU_LATENCY - 1));
  assign last_lane = (k_q == KW'(LANES - 1));

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    wcnt_d    = wcnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    cin_d     = cin_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    alu_cin_d = alu_cin_q;
    res_d     = res_q;
    carry_d   = carry_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d   = S_ISSUE;
          a_d       = cmd_a;
          b_d       = cmd_b;
          op_d      = cmd_opcode;
          cin_d     = cmd_carry_in;
          k_d       = '0;
          wcnt_d    = '0;
          alu_a_d   = cmd_a[WIDTH-1:0];
          alu_b_d   = cmd_b[WIDTH-1:0];
          alu_op_d  = cmd_opcode;
          alu_cin_d = cmd_carry_in;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wcnt_d  = '0;
      end
      S_WAIT: begin
        if (last_wait) begin
          res_d[k_q*WIDTH +: WIDTH] = alu_sum;
          carry_d = alu_carry_out;
          wcnt_d  = '0;
          if (last_lane) begin
            state_d = S_RESP;
          end else begin
            // Non-chained opcodes reuse the command carry so lanes stay independent.
            state_d   = S_ISSUE;
            k_d       = k_nxt;
            alu_a_d   = a_q[k_nxt*WIDTH +: WIDTH];
            alu_b_d   = b_q[k_nxt*WIDTH +: WIDTH];
            alu_cin_d = CHAIN_MASK[op_q] ? alu_carry_out : cin_q;
          end
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      wcnt_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      cin_q     <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      alu_cin_q <= 1'b0;
      res_q     <= '0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      wcnt_q    <= wcnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      cin_q     <= cin_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      alu_cin_q <= alu_cin_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
    end
  end

  assign alu_in_a     = alu_a_q;
  assign alu_in_b     = alu_b_q;
  assign alu_opcode   = alu_op_q;
  assign alu_carry_in = alu_cin_q;
  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_result   = res_q;
  assign rsp_carry    = carry_q;

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic zero_q;
  logic fin_op;

  assign fin_op = (state_q == S_WAIT) && last_wait && last_lane;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      zero_q <= 1'b0;
    else if (fin_op) zero_q <= (res_d == '0);
  end

  assign rsp_zero = zero_q;
`else
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: default instance plus an ALU_LATENCY=3 instance,
// each driving a behavioural ALU (op 0 = ADD with carry, op 2 = AND).
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // default instance
  logic        cmd_valid, cmd_ready, cmd_carry_in;
  logic [3:0]  cmd_opcode;
  logic [31:0] cmd_a, cmd_b;
  logic [7:0]  alu_in_a, alu_in_b, alu_sum;
  logic [3:0]  alu_opcode;
  logic        alu_carry_in, alu_carry_out;
  logic        rsp_valid, rsp_ready, rsp_carry;
  logic [31:0] rsp_result;
  // latency-3 instance
  logic        cmd_valid3, cmd_ready3, cmd_carry_in3;
  logic [3:0]  cmd_opcode3;
  logic [31:0] cmd_a3, cmd_b3;
  logic [7:0]  alu_in_a3, alu_in_b3, alu_sum3;
  logic [3:0]  alu_opcode3;
  logic        alu_carry_in3, alu_carry_out3;
  logic        rsp_valid3, rsp_ready3, rsp_carry3;
  logic [31:0] rsp_result3;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic        rsp_zero, rsp_zero3;
`endif

  alu_seq u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_carry_in(cmd_carry_in),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_opcode(alu_opcode),
    .alu_carry_in(alu_carry_in), .alu_sum(alu_sum), .alu_carry_out(alu_carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , .rsp_zero(rsp_zero)
`endif
  );

  alu_seq #(.ALU_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_opcode(cmd_opcode3),
    .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_carry_in(cmd_carry_in3),
    .alu_in_a(alu_in_a3), .alu_in_b(alu_in_b3), .alu_opcode(alu_opcode3),
    .alu_carry_in(alu_carry_in3), .alu_sum(alu_sum3), .alu_carry_out(alu_carry_out3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
    .rsp_carry(rsp_carry3)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , .rsp_zero(rsp_zero3)
`endif
  );

  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic cin);
    case (op)
      4'd0:    alu_f = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      4'd2:    alu_f = {1'b0, a & b};
      default: alu_f = '0;
    endcase
  endfunction

  logic [8:0] p1 = '0;
  logic [8:0] p3 [3];
  initial for (int i = 0; i < 3; i++) p3[i] = '0;

  always @(posedge clk) begin
    p1    <= alu_f(alu_opcode, alu_in_a, alu_in_b, alu_carry_in);
    p3[0] <= alu_f(alu_opcode3, alu_in_a3, alu_in_b3, alu_carry_in3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign {alu_carry_out, alu_sum}   = p1;
  assign {alu_carry_out3, alu_sum3} = p3[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic cin);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_carry_in = cin;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_opcode = 4'hF; cmd_a = ~a; cmd_b = ~b; cmd_carry_in = ~cin;
    chk("cmd_ready_busy", cmd_ready, 0);
  endtask

  task automatic wait_rsp(input int exp_cyc, input bit chk_cin, input logic cin_exp);
    int cyc = 0;
    while (!rsp_valid && cyc < 100) begin
      if (chk_cin) chk("alu_carry_in_slice", alu_carry_in, cin_exp);
      @(posedge clk); #1;
      cyc++;
    end
    chk("rsp_latency", cyc, exp_cyc);
  endtask

  task automatic expect_rsp(input logic [31:0] res, input logic carry, input logic zero);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_result", rsp_result, res);
    chk("rsp_carry", rsp_carry, carry);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("rsp_zero", rsp_zero, zero);
`else
    if (zero === 1'bx) chk("zero_arg", zero, 0);
`endif
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("cmd_ready_after_rsp", cmd_ready, 1);
  endtask

  initial begin
    int cyc;
    int seen;
    cmd_valid = 0; cmd_opcode = 0; cmd_a = 0; cmd_b = 0; cmd_carry_in = 0; rsp_ready = 0;
    cmd_valid3 = 0; cmd_opcode3 = 0; cmd_a3 = 0; cmd_b3 = 0; cmd_carry_in3 = 0; rsp_ready3 = 0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_carry", rsp_carry, 0);
    chk("rst_alu_in_a", alu_in_a, 0);
    chk("rst_alu_in_b", alu_in_b, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_alu_carry_in", alu_carry_in, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;

    // ADD with carry rippling from slice 0 into slice 1
    send(4'd0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    chk("slice0_alu_in_a", alu_in_a, 8'hFF);
    chk("slice0_alu_in_b", alu_in_b, 8'h01);
    wait_rsp(8, 1'b0, 1'b0);
    expect_rsp(32'h0000_0100, 1'b0, 1'b0);
    handshake();

    // full wrap
    send(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_rsp(8, 1'b0, 1'b0);
    expect_rsp(32'h0000_0000, 1'b1, 1'b1);
    handshake();

    // non-chained AND: every slice sees the command carry
    send(4'd2, 32'hF0F0_FFFF, 32'h0FF0_00FF, 1'b1);
    wait_rsp(8, 1'b1, 1'b1);
    expect_rsp(32'h00F0_00FF, 1'b0, 1'b0);
    handshake();

    // backpressure then a second command on the cycle after rsp_ready
    send(4'd0, 32'h0101_0101, 32'h0202_0202, 1'b1);
    wait_rsp(8, 1'b0, 1'b0);
    expect_rsp(32'h0303_0304, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_result", rsp_result, 32'h0303_0304);
      chk("bp_rsp_carry", rsp_carry, 0);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_opcode = 4'd0; cmd_a = 32'h8000_0000; cmd_b = 32'h8000_0000;
    cmd_carry_in = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_rsp_valid_drop", rsp_valid, 0);
    chk("bp_cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_a = 32'h1234_5678;
    chk("bp_second_accepted", cmd_ready, 0);
    wait_rsp(8, 1'b0, 1'b0);
    expect_rsp(32'h0000_0000, 1'b1, 1'b1);
    handshake();

    // asynchronous reset during slice 2 WAIT
    send(4'd0, 32'h5566_7788, 32'h1122_3344, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_alu_in_a", alu_in_a, 8'h66);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_result", rsp_result, 0);
    chk("mid_rst_rsp_carry", rsp_carry, 0);
    chk("mid_rst_alu_in_a", alu_in_a, 0);
    chk("mid_rst_alu_in_b", alu_in_b, 0);
    chk("mid_rst_alu_opcode", alu_opcode, 0);
    chk("mid_rst_alu_carry_in", alu_carry_in, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_reset", seen, 0);
    send(4'd0, 32'h5566_7788, 32'h1122_3344, 1'b0);
    wait_rsp(8, 1'b0, 1'b0);
    expect_rsp(32'h6688_AACC, 1'b0, 1'b0);
    handshake();

    // ALU_LATENCY = 3 instance
    chk("l3_cmd_ready_idle", cmd_ready3, 1);
    cmd_valid3 = 1'b1; cmd_opcode3 = 4'd0; cmd_a3 = 32'h1234_5678; cmd_b3 = 32'h1111_1111;
    cmd_carry_in3 = 1'b0;
    @(posedge clk); #1;
    cmd_valid3 = 1'b0; cmd_a3 = '0; cmd_b3 = '0;
    cyc = 0;
    while (!rsp_valid3 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("l3_rsp_latency", cyc, 16);
    chk("l3_rsp_result", rsp_result3, 32'h2345_6789);
    chk("l3_rsp_carry", rsp_carry3, 0);
    rsp_ready3 = 1'b1;
    @(posedge clk); #1;
    rsp_ready3 = 1'b0;
    chk("l3_rsp_valid_drop", rsp_valid3, 0);
    chk("l3_cmd_ready_after", cmd_ready3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
